// File: rtl/sram_rd_streamer_if.sv
// Stream bundle from sram_rd_streamer to the solver datapath.
// Ports: out_valid/out_data/out_last (master out), out_ready (master in).
interface sram_rd_streamer_if #(
  parameter int BITS = 32
);
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] out_data;
  logic            out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/sram_rd_streamer.sv
// Strided read streamer for the 1024x32 SRAM port B.
// Ports: CLK/RST, start/base_addr/stride/len command,
//   SRAM B (CENB WENB AB DB QB), strm stream, busy, done.
module sram_rd_streamer #(
  parameter int BITS       = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  CENB,
  output logic                  WENB,
  output logic [ADDR_WIDTH-1:0] AB,
  output logic [BITS-1:0]       DB,
  input  logic [BITS-1:0]       QB,
  sram_rd_streamer_if.master    strm,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic                  infl_q;
  logic                  infl_last_q;
  logic [BITS-1:0]       fdat_q [2];
  logic [1:0]            flast_q;
  logic                  rd_q;
  logic                  wr_q;
  logic [1:0]            cnt_q;
  logic                  done_q;

  logic [1:0] occ;
  logic       pop;
  logic       push;
  logic       issue;
  logic       accept;
  logic       fin;
  logic       last_rd;

  assign pop     = strm.out_valid && strm.out_ready;
  assign push    = infl_q;
  assign occ     = cnt_q + {1'b0, infl_q};
  assign last_rd = rem_q == LEN_WIDTH'(1);
  assign accept  = (state_q == IDLE) && start;
  assign fin     = (state_q == DRAIN) && pop
                && flast_q[rd_q];

  // A slot freed by this cycle's pop may be refilled now,
  // which keeps one word per cycle with ready held high.
  assign issue = (state_q == RUN)
              && (rem_q != '0)
              && ((occ - {1'b0, pop}) < 2'd2);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (start && (len != '0)) state_d = RUN;
      RUN:
        if (issue && last_rd) state_d = DRAIN;
      DRAIN:
        if (fin) state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      stride_q    <= '0;
      rem_q       <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      fdat_q[0]   <= '0;
      fdat_q[1]   <= '0;
      flast_q     <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_q      <= (accept && (len == '0)) || fin;
      infl_q      <= issue;
      infl_last_q <= issue && last_rd;
      if (accept) begin
        addr_q   <= base_addr;
        stride_q <= stride;
        rem_q    <= len;
      end else if (issue) begin
        addr_q <= addr_q + stride_q;
        rem_q  <= rem_q - LEN_WIDTH'(1);
      end
      // The last flag travels with the read so the
      // head entry knows it is the final word.
      if (push) begin
        fdat_q[wr_q]  <= QB;
        flast_q[wr_q] <= infl_last_q;
        wr_q          <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign strm.out_valid = cnt_q != '0;
  assign strm.out_data  = strm.out_valid ?
                          fdat_q[rd_q] : '0;
  assign strm.out_last  = strm.out_valid
                       && flast_q[rd_q];

  assign CENB = ~issue;
  assign WENB = 1'b1;
  assign DB   = '0;
  assign AB   = addr_q;
  assign busy = state_q != IDLE;
  assign done = done_q;

endmodule

// File: tb/tb_sram_rd_streamer.sv
// Scoreboard bench for sram_rd_streamer with an SRAM model.
// Ports: none; drives commands and ready, checks the stream.
module tb_sram_rd_streamer;
  localparam int BITS = 32;
  localparam int AW   = 10;
  localparam int LW   = 11;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            start = 1'b0;
  logic [AW-1:0]   base_addr = '0;
  logic [AW-1:0]   stride = '0;
  logic [LW-1:0]   len = '0;
  logic            CENB, WENB;
  logic [AW-1:0]   AB;
  logic [BITS-1:0] DB;
  logic [BITS-1:0] QB;
  logic            busy, done;

  sram_rd_streamer_if #(.BITS(BITS)) strm ();

  sram_rd_streamer #(
    .BITS(BITS), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)
  ) dut (
    .CLK(CLK), .RST(RST), .start(start),
    .base_addr(base_addr), .stride(stride), .len(len),
    .CENB(CENB), .WENB(WENB), .AB(AB), .DB(DB),
    .QB(QB), .strm(strm), .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  logic [BITS-1:0] mem [1024];
  initial for (int i = 0; i < 1024; i++) mem[i] = i;
  always @(posedge CLK) if (!CENB) QB <= mem[AB];

  typedef struct {
    logic [BITS-1:0] d;
    logic            l;
  } exp_t;
  exp_t sbq[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // ready driver: 0 always high, 1 random, 2 fixed pattern
  int rmode = 0;
  int pidx  = 0;
  logic [5:0] pat = 6'b101001;
  initial strm.out_ready = 1'b1;
  always @(posedge CLK) begin
    #1;
    case (rmode)
      1: strm.out_ready = 1'($urandom_range(0, 1));
      2: begin
        strm.out_ready = pat[pidx % 6];
        pidx++;
      end
      default: strm.out_ready = 1'b1;
    endcase
  end

  // monitor / scoreboard
  int              outst = 0;
  bit              exp_done = 0;
  bit              stall_prev = 0;
  logic [BITS-1:0] stall_data;
  bit              hs;
  exp_t            e;
  always @(negedge CLK) begin
    if (RST) begin
      sbq.delete();
      outst = 0;
      exp_done = 0;
      stall_prev = 0;
    end else begin
      hs = strm.out_valid && strm.out_ready;
      if (done || exp_done) chk("done", done, exp_done);
      if (!CENB) chk("occupancy", (outst - int'(hs)) < 2, 1);
      if (stall_prev) begin
        chk("stall_valid", strm.out_valid, 1);
        chk("stall_data", strm.out_data, stall_data);
      end
      if (hs) begin
        if (sbq.size() == 0) begin
          chk("extra_word", strm.out_data, 64'hDEAD);
        end else begin
          e = sbq.pop_front();
          chk("data", strm.out_data, e.d);
          chk("last", strm.out_last, e.l);
        end
      end
      exp_done = (hs && strm.out_last) ||
                 (start && !busy && len == '0);
      outst = outst + int'(!CENB) - int'(hs);
      stall_prev = strm.out_valid && !strm.out_ready;
      stall_data = strm.out_data;
    end
  end

  task automatic push_exp(input int b, input int s, input int l);
    exp_t x;
    for (int k = 0; k < l; k++) begin
      x.d = mem[(b + k * s) % 1024];
      x.l = (k == l - 1);
      sbq.push_back(x);
    end
  endtask

  // drives start for exactly cycle 0; returns in cycle 1
  task automatic issue(input int b, input int s, input int l,
                       input bit expect_it);
    @(posedge CLK); #1;
    start = 1'b1;
    base_addr = AW'(b);
    stride = AW'(s);
    len = LW'(l);
    if (expect_it) push_exp(b, s, l);
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    @(negedge CLK);
    while ((busy || sbq.size() != 0 || done) && n < 5000) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 5000) chk({nm, "_timeout"}, 1, 0);
  endtask

  task automatic nxt(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_CENB"}, CENB, 1);
    chk({nm, "_WENB"}, WENB, 1);
    chk({nm, "_AB"}, AB, 0);
    chk({nm, "_DB"}, DB, 0);
    chk({nm, "_valid"}, strm.out_valid, 0);
    chk({nm, "_data"}, strm.out_data, 0);
    chk({nm, "_last"}, strm.out_last, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk_reset_vals("rst");

    // row read with cycle-exact latency
    rmode = 0;
    issue(5, 1, 4, 1);
    nxt(1);
    chk("c1_busy", busy, 1);
    chk("c1_CENB", CENB, 0);
    chk("c1_AB", AB, 5);
    nxt(1);
    chk("c2_valid", strm.out_valid, 0);
    nxt(1);
    chk("c3_valid", strm.out_valid, 1);
    chk("c3_data", strm.out_data, 5);
    nxt(3);
    chk("c6_data", strm.out_data, 8);
    chk("c6_last", strm.out_last, 1);
    nxt(1);
    chk("c7_done", done, 1);
    chk("c7_busy", busy, 0);
    wait_idle("row");

    // column read wrapping past the top of memory
    issue(1020, 8, 3, 1);
    wait_idle("col");

    // zero length
    issue(9, 1, 0, 0);
    nxt(1);
    chk("z_done", done, 1);
    chk("z_busy", busy, 0);
    chk("z_CENB", CENB, 1);
    wait_idle("zero");

    // start while busy is ignored
    issue(40, 3, 10, 1);
    nxt(1);
    @(posedge CLK); #1;
    start = 1'b1;
    base_addr = 10'd500;
    len = 11'd5;
    @(posedge CLK); #1;
    start = 1'b0;
    wait_idle("ign");

    // backpressure pattern
    rmode = 2;
    pidx = 0;
    issue(200, 7, 6, 1);
    wait_idle("bp");
    rmode = 0;

    // reset in cycle 4 of a len=8 read
    issue(100, 3, 8, 1);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(negedge CLK);
    chk_reset_vals("midrst");
    nxt(1);
    chk("midrst_nodone", done, 0);
    issue(7, 2, 5, 1);
    wait_idle("after_rst");

    // randomized commands under random backpressure
    rmode = 1;
    for (int t = 0; t < 25; t++) begin
      int b, s, l;
      b = $urandom_range(0, 1023);
      s = ($urandom_range(0, 3) == 0) ? 0 :
          $urandom_range(0, 1023);
      l = $urandom_range(0, 40);
      issue(b, s, l, 1);
      wait_idle("rand");
    end

    // whole memory
    rmode = 0;
    issue(0, 1, 1024, 1);
    wait_idle("full");

    chk("sb_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sram_rd_streamer.md
# sram_rd_streamer

Read-side stream controller for the 1024x32 dual-port data SRAM. On a start command it walks port B through `len` words beginning at `base_addr` with a programmable `stride`, so the same block serves row reads (stride 1) and column reads (stride N). It absorbs the SRAM's one-cycle registered read latency and presents the words as a valid/ready stream to the downstream solver datapath. A 2-entry output buffer lets it sustain full throughput under backpressure.

## Interface
Parameters:
- BITS, 32, data word width; must match the SRAM.
- ADDR_WIDTH, 10, SRAM address width.
- LEN_WIDTH, 11, width of `len`; allows 0..1024 words.

Ports:
- CLK  in  1  clock; drives both this block and the SRAM.
- RST  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first word address; sampled with `start`.
- stride  in  ADDR_WIDTH  address increment per word; sampled with `start`.
- len  in  LEN_WIDTH  number of words; sampled with `start`.
- CENB  out  1  SRAM port-B chip enable, active-low.
- WENB  out  1  SRAM port-B write enable; constant 1 (read only).
- AB  out  ADDR_WIDTH  SRAM port-B address.
- DB  out  BITS  SRAM port-B write data; constant 0.
- QB  in  BITS  SRAM port-B read data; valid in the cycle after a CENB-low cycle.
- out_valid  out  1  stream data valid.
- out_ready  in  1  downstream accept.
- out_data  out  BITS  stream word.
- out_last  out  1  high with the final word of the command.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when the command completes.

## Operation
- **FSM states:** IDLE, RUN, DRAIN.
  - IDLE → RUN on `start` with `len`≠0. This latches addr=base_addr, stride, remaining=len, emitted=0.
  - `start` with `len`=0 gives no reads, a `done` pulse in the next cycle, and the FSM stays in IDLE.
  - RUN → DRAIN when the last read issues (remaining becomes 0).
  - DRAIN → IDLE when the final word is handshaken. `done` pulses in the following cycle.
- `start` while busy is ignored.
- **Handshake:** a transfer occurs when out_valid && out_ready.
- **Buffer accounting:**
  - occupancy = fifo_count + inflight, where inflight is 1 if CENB was low in the previous cycle. Occupancy never exceeds 2.
  - pop = out_valid && out_ready.
- **Read issue:** CENB=0 iff state is RUN, remaining>0 and (occupancy − pop) < 2. CENB is combinational from registered state and out_ready; AB=addr register.
- **On each issue:** addr ← (addr + stride) mod 2^ADDR_WIDTH (wrap-around is legal); remaining ← remaining−1.
- **Data capture:** when inflight=1, QB is pushed into the 2-entry FIFO. Push and pop in the same cycle are allowed.
- **Output stream:**
  - out_data and out_valid come from the FIFO head.
  - out_last=1 when the head word is word index len−1.
  - out_data holds stable while out_valid && !out_ready.
- **Special cases:**
  - stride=0 is legal: the same word is read `len` times.
  - len=1024 reads the whole memory.
- **RST at any time:**
  - State ← IDLE, FIFO emptied, counters cleared.
  - Any in-flight QB is discarded.
  - No `done` pulse is generated.

## Timing
- **Reset values:** CENB=1, WENB=1, AB=0, DB=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0.
- **Latency** (start sampled high in cycle 0):
  - cycle 1: busy=1, CENB=0, AB=base_addr;
  - cycle 2: QB valid, pushed at the end of the cycle;
  - cycle 3: out_valid=1 with word 0.
- **Throughput:** with out_ready held high, word k is presented in cycle 3+k. One word per cycle, no bubbles.
- **Backpressure:** after out_ready drops, at most 2 words are buffered and issue stops. Issue resumes in the same cycle out_ready returns high.
- **Completion:** `done` pulses in the cycle after the last handshake, coinciding with busy=0. A new `start` is accepted in that same cycle.

## Test plan
- **Row read:** memory preloaded mem[i]=i. start, base=5, stride=1, len=4, out_ready=1 → data 5,6,7,8 in cycles 3–6; out_last in cycle 6; done in cycle 7.
- **Column read with wrap:** base=1020, stride=8, len=3 → addresses 1020, 4, 12; data mem[1020], mem[4], mem[12].
- **Backpressure:** len=6, out_ready toggled 1,0,0,1,0,1,… → all six words in order with no loss or duplication; CENB never low when occupancy−pop=2; out_data stable while stalled.
- **Zero length and ignored start:** len=0 → no CENB-low cycle, done in cycle 1, busy stays 0. A start pulsed mid-command → ignored, original sequence unchanged.
- **Reset mid-operation:** RST in cycle 4 of a len=8 read → next cycle shows all outputs at reset values, no done pulse. A fresh start afterwards streams correctly from its own base_addr.
- **Full memory:** len=1024, base=0, stride=1 → 1024 words, out_last only on word 1023, done 1 cycle after it.
